// File: rtl/nn_layer_sequencer_pkg.sv
// Shared definitions for the digit-classifier layer sequencer: state encoding
// and default layer sizes.
package nn_pkg;

  localparam int N_PIXELS_DEF = 784;
  localparam int N_OUT_DEF    = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BIAS    = 3'd1,
    ST_PIXEL   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_READOUT = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/nn_layer_sequencer_valid_delay.sv
// Single-bit shift-register delay of DEPTH stages with synchronous flush and
// asynchronous reset; q is the last stage.
module nn_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_r;

  generate
    if (DEPTH == 1) begin : g_one
      // Single register stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr_r <= 1'b0;
        end else if (flush) begin
          sr_r <= 1'b0;
        end else begin
          sr_r <= d;
        end
      end
    end else begin : g_many
      // Multi-stage shift toward the MSB
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr_r <= {DEPTH{1'b0}};
        end else if (flush) begin
          sr_r <= {DEPTH{1'b0}};
        end else begin
          sr_r <= {sr_r[DEPTH-2:0], d};
        end
      end
    end
  endgenerate

  assign q = sr_r[DEPTH-1];

endmodule

// File: rtl/nn_layer_sequencer.sv
// Control sequencer for the fully-connected classifier: per image, one-hot bias
// load, stall-aware pixel streaming, pipeline drain and output-neuron readout.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int N_PIXELS  = N_PIXELS_DEF,
  parameter int N_OUT     = N_OUT_DEF,
  parameter int PIX_AW    = 10,
  parameter int OUT_AW    = 4,
  parameter int PIPE_LAT  = 2,
  parameter int DRAIN_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pix_avail,
  output logic              busy,
  output logic              done,
  output logic [OUT_AW-1:0] bias_addr,
  output logic [N_OUT-1:0]  bias_load,
  output logic [PIX_AW-1:0] pixel_addr,
  output logic              valid_pixel,
  output logic [OUT_AW-1:0] out_addr,
  output logic [OUT_AW-1:0] out_addr_d,
  output logic              valid_digit
);

  // No pixel enters the delay line in DRAIN, so it is empty PIPE_LAT cycles
  // after entry; the drain count covers that plus DRAIN_CYC.
  localparam int DCW = $clog2(PIPE_LAT + DRAIN_CYC + 1);

  localparam logic [OUT_AW-1:0] OUT_LAST   = OUT_AW'(N_OUT - 1);
  localparam logic [OUT_AW-1:0] OUT_ONE    = OUT_AW'(1);
  localparam logic [OUT_AW-1:0] OUT_ZERO   = OUT_AW'(0);
  localparam logic [PIX_AW-1:0] PIX_LAST   = PIX_AW'(N_PIXELS - 1);
  localparam logic [PIX_AW-1:0] PIX_ONE    = PIX_AW'(1);
  localparam logic [PIX_AW-1:0] PIX_ZERO   = PIX_AW'(0);
  localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(PIPE_LAT + DRAIN_CYC - 1);
  localparam logic [DCW-1:0]    DCW_ONE    = DCW'(1);
  localparam logic [DCW-1:0]    DCW_ZERO   = DCW'(0);
  localparam logic [N_OUT-1:0]  LOAD_FIRST = N_OUT'(1);
  localparam logic [N_OUT-1:0]  LOAD_NONE  = N_OUT'(0);

  seq_state_e     state_r;
  logic [DCW-1:0] drain_cnt_r;
  logic           issue_s;
  logic           readout_s;

  assign issue_s   = (state_r == ST_PIXEL) && pix_avail;
  assign readout_s = (state_r == ST_READOUT);

  // Sequencer FSM with registered handshake and address outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      bias_addr   <= OUT_ZERO;
      bias_load   <= LOAD_NONE;
      pixel_addr  <= PIX_ZERO;
      out_addr    <= OUT_ZERO;
      drain_cnt_r <= DCW_ZERO;
    end else if (abort) begin
      state_r   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bias_load <= LOAD_NONE;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r     <= ST_BIAS;
            busy        <= 1'b1;
            bias_addr   <= OUT_ZERO;
            bias_load   <= LOAD_FIRST;
            pixel_addr  <= PIX_ZERO;
            out_addr    <= OUT_ZERO;
            drain_cnt_r <= DCW_ZERO;
          end
        end
        ST_BIAS: begin
          if (bias_addr == OUT_LAST) begin
            bias_load <= LOAD_NONE;
            state_r   <= ST_PIXEL;
          end else begin
            bias_addr <= bias_addr + OUT_ONE;
            bias_load <= bias_load << 1'b1;
          end
        end
        ST_PIXEL: begin
          if (issue_s) begin
            if (pixel_addr == PIX_LAST) begin
              state_r <= ST_DRAIN;
            end else begin
              pixel_addr <= pixel_addr + PIX_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r  <= ST_READOUT;
            out_addr <= OUT_ZERO;
          end else begin
            drain_cnt_r <= drain_cnt_r + DCW_ONE;
          end
        end
        ST_READOUT: begin
          if (out_addr == OUT_LAST) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            out_addr <= out_addr + OUT_ONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy      <= 1'b0;
          bias_load <= LOAD_NONE;
        end
      endcase
    end
  end

  // Readout address delayed to line up with the registered neuron mux
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr_d <= OUT_ZERO;
    end else begin
      out_addr_d <= out_addr;
    end
  end

  nn_valid_delay #(.DEPTH(PIPE_LAT)) u_pix_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .d     (issue_s),
    .q     (valid_pixel)
  );

  nn_valid_delay #(.DEPTH(1)) u_dig_dly (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .d     (readout_s),
    .q     (valid_digit)
  );

endmodule
